// File: rtl/cr16_control_fsm.sv
// Multicycle control unit for the CR16-subset core: sequences fetch, decode,
// execute, memory and writeback, driving every datapath enable and mux select.
module cr16_control_fsm #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instr,
    input  logic [7:0]       PSROut,
    input  logic             memReady,
    output logic             PCEN,
    output logic             PSREN,
    output logic             nextInstruction,
    output logic             updateAddress,
    output logic             StoreReg,
    output logic             WriteData,
    output logic             regWrite,
    output logic             memWrite,
    output logic             ZeroExtend,
    output logic             PCinstruction,
    output logic             SrcB,
    output logic             shiftType,
    output logic [3:0]       ALUcond,
    output logic             JmpEN,
    output logic             BranchEN,
    output logic             JALEN,
    output logic [1:0]       chooseResult,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        ALU_EX   = 4'd2,
        SHIFT_EX = 4'd3,
        LOAD_ADR = 4'd4,
        LOAD_WB  = 4'd5,
        STORE    = 4'd6,
        BRANCH   = 4'd7,
        JUMP     = 4'd8,
        JAL_LINK = 4'd9,
        JAL_JUMP = 4'd10
    } state_t;

    state_t curState_r;
    state_t nextState_s;

    logic [REGBITS-1:0] op_s;
    logic [REGBITS-1:0] cond_s;
    logic [REGBITS-1:0] ext_s;
    logic [REGBITS-1:0] aluOp_s;
    logic               condTrue_s;
    logic               unusedBits_s;

    assign op_s   = instr[15:12];
    assign cond_s = instr[11:8];
    assign ext_s  = instr[7:4];

    // Rsrc and the reserved flag bits play no part in control decode.
    assign unusedBits_s = ^{instr[3:0], PSROut[4:3], PSROut[1]};

    function automatic logic evalCond(input logic [3:0] cond, input logic c, input logic l,
                                      input logic f, input logic z, input logic n);
        logic result;
        case (cond)
            4'b0000: result = z;
            4'b0001: result = ~z;
            4'b0010: result = c;
            4'b0011: result = ~c;
            4'b0100: result = l;
            4'b0101: result = ~l;
            4'b0110: result = n;
            4'b0111: result = ~n;
            4'b1000: result = f;
            4'b1001: result = ~f;
            4'b1010: result = ~l & ~z;
            4'b1011: result = l | z;
            4'b1100: result = ~n & ~z;
            4'b1101: result = n | z;
            4'b1110: result = 1'b1;
            4'b1111: result = 1'b0;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    assign condTrue_s = evalCond(cond_s, PSROut[0], PSROut[2], PSROut[5], PSROut[6], PSROut[7]);
    assign aluOp_s    = (op_s == 4'b0000) ? ext_s : op_s;
    assign state      = curState_r;

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState_r <= FETCH;
        end else begin
            curState_r <= nextState_s;
        end
    end

    // Next-state and output decode; everything is forced low while reset is held.
    always_comb begin
        nextState_s     = curState_r;
        PCEN            = 1'b0;
        PSREN           = 1'b0;
        nextInstruction = 1'b0;
        updateAddress   = 1'b0;
        StoreReg        = 1'b0;
        WriteData       = 1'b0;
        regWrite        = 1'b0;
        memWrite        = 1'b0;
        ZeroExtend      = 1'b0;
        PCinstruction   = 1'b0;
        SrcB            = 1'b0;
        shiftType       = 1'b0;
        ALUcond         = 4'b0000;
        JmpEN           = 1'b0;
        BranchEN        = 1'b0;
        JALEN           = 1'b0;
        chooseResult    = 2'b00;
        if (!reset) begin
            nextState_s = FETCH;
        end else begin
            case (curState_r)
                FETCH: begin
                    updateAddress = 1'b1;
                    if (memReady) begin
                        nextInstruction = 1'b1;
                        PCEN            = 1'b1;
                        PCinstruction   = 1'b1;
                        nextState_s     = DECODE;
                    end else begin
                        nextState_s = FETCH;
                    end
                end
                DECODE: begin
                    case (op_s)
                        4'b0000, 4'b0001, 4'b0010, 4'b0011,
                        4'b0101, 4'b1001, 4'b1011, 4'b1101, 4'b1111: nextState_s = ALU_EX;
                        4'b1000: nextState_s = SHIFT_EX;
                        4'b1100: nextState_s = BRANCH;
                        4'b0100: begin
                            case (ext_s)
                                4'b0000: nextState_s = LOAD_ADR;
                                4'b0100: nextState_s = STORE;
                                4'b1000: nextState_s = JAL_LINK;
                                4'b1100: nextState_s = JUMP;
                                default: nextState_s = FETCH;
                            endcase
                        end
                        default: nextState_s = FETCH;
                    endcase
                end
                ALU_EX: begin
                    ALUcond      = aluOp_s;
                    SrcB         = (op_s == 4'b0000);
                    ZeroExtend   = (op_s == 4'b0001) || (op_s == 4'b0010) || (op_s == 4'b0011);
                    chooseResult = 2'b01;
                    WriteData    = 1'b1;
                    PSREN        = 1'b1;
                    regWrite     = (aluOp_s != 4'b1011);
                    nextState_s  = FETCH;
                end
                SHIFT_EX: begin
                    shiftType    = ~ext_s[2];
                    chooseResult = 2'b00;
                    WriteData    = 1'b1;
                    regWrite     = 1'b1;
                    nextState_s  = FETCH;
                end
                LOAD_ADR: begin
                    nextState_s = memReady ? LOAD_WB : LOAD_ADR;
                end
                LOAD_WB: begin
                    regWrite    = 1'b1;
                    nextState_s = FETCH;
                end
                STORE: begin
                    StoreReg    = 1'b1;
                    memWrite    = 1'b1;
                    nextState_s = memReady ? FETCH : STORE;
                end
                BRANCH: begin
                    BranchEN    = 1'b1;
                    PCEN        = condTrue_s;
                    nextState_s = FETCH;
                end
                JUMP: begin
                    JmpEN       = 1'b1;
                    SrcB        = 1'b1;
                    PCEN        = condTrue_s;
                    nextState_s = FETCH;
                end
                JAL_LINK: begin
                    chooseResult = 2'b11;
                    WriteData    = 1'b1;
                    regWrite     = 1'b1;
                    nextState_s  = JAL_JUMP;
                end
                JAL_JUMP: begin
                    JALEN       = 1'b1;
                    PCEN        = 1'b1;
                    nextState_s = FETCH;
                end
                default: begin
                    nextState_s = FETCH;
                end
            endcase
        end
    end

endmodule
